sys_bridge_mc: RTL and testbench

Parametrised multi-device system bridge between the MIPS core's data-memory port and N peripheral devices. It decodes a device select field from the processor word address and steers store data onto the correct byte lanes from the byte enables. A request/acknowledge handshake with per-access timeout runs each access, and the bridge returns registered read data plus done and error status. It also synchronises and aggregates the device interrupt lines into the core's hardware-interrupt vector.

---
 rtl/sys_bridge_mc.sv | 113 +++++++++++
 tb/tb_sys_bridge_mc.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sys_bridge_mc.sv
// sys_bridge_mc: MIPS data-port bridge to N devices with lane steering,
// req/ack handshake with timeout, and synchronised interrupt aggregation.
module sys_bridge_mc #(
  parameter int N_DEV   = 4,
  parameter int SEL_W   = 2,
  parameter int SEL_LO  = 8,
  parameter int DEV_AW  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  PrReq_I,
  input  logic                  PrWE_I,
  input  logic [31:2]           PrAddr_I,
  input  logic [31:0]           PrWD_I,
  input  logic [3:0]            BE_I,
  output logic [31:0]           PrRD_O,
  output logic                  PrBusy_O,
  output logic                  PrDone_O,
  output logic                  PrErr_O,
  output logic [N_DEV-1:0]      DEV_Req_O,
  output logic                  DEV_WE_O,
  output logic [3:0]            DEV_BE_O,
  output logic [DEV_AW-1:0]     DEV_Addr_O,
  output logic [31:0]           DEV_WD_O,
  input  logic [N_DEV*32-1:0]   DEV_RD_I,
  input  logic [N_DEV-1:0]      DEV_Ack_I,
  input  logic [N_DEV-1:0]      DEV_Int_I,
  output logic [N_DEV-1:0]      HWInt_O
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t           state;
  logic [SEL_W-1:0] sel, sel_in;
  logic [CW-1:0]    cnt;
  logic [31:0]      steer, rd_mux;
  logic             legal, ack, unused;
  logic [N_DEV-1:0] int_meta;
  assign sel_in = PrAddr_I[SEL_LO+SEL_W-1:SEL_LO];
  assign legal  = (BE_I inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000})
                  && (int'(sel_in) < N_DEV);
  assign steer  = BE_I == 4'b1111 ? PrWD_I :
                  BE_I == 4'b0011 ? {16'b0, PrWD_I[15:0]} :
                  BE_I == 4'b1100 ? {PrWD_I[15:0], 16'b0} :
                  BE_I == 4'b0001 ? {24'b0, PrWD_I[7:0]} :
                  BE_I == 4'b0010 ? {16'b0, PrWD_I[7:0], 8'b0} :
                  BE_I == 4'b0100 ? {8'b0, PrWD_I[7:0], 16'b0} :
                  BE_I == 4'b1000 ? {PrWD_I[7:0], 24'b0} : 32'b0;
  assign PrBusy_O = (state != IDLE) || PrReq_I;
  assign unused   = ^PrAddr_I;
  always_comb begin
    rd_mux = '0;
    ack    = 1'b0;
    for (int k = 0; k < N_DEV; k++)
      if (int'(sel) == k) begin
        rd_mux = DEV_RD_I[32*k +: 32];
        ack    = DEV_Ack_I[k];
      end
  end
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state      <= IDLE;
      sel        <= '0;
      cnt        <= '0;
      PrRD_O     <= '0;
      PrDone_O   <= 1'b0;
      PrErr_O    <= 1'b0;
      DEV_Req_O  <= '0;
      DEV_WE_O   <= 1'b0;
      DEV_BE_O   <= '0;
      DEV_Addr_O <= '0;
      DEV_WD_O   <= '0;
    end else begin
      case (state)
        IDLE: if (PrReq_I) begin
          sel        <= sel_in;
          DEV_WE_O   <= PrWE_I;
          DEV_BE_O   <= BE_I;
          DEV_Addr_O <= PrAddr_I[DEV_AW+1:2];
          DEV_WD_O   <= steer;
          cnt        <= '0;
          if (legal) begin
            state     <= ACCESS;
            DEV_Req_O <= N_DEV'(1) << sel_in;
          end else begin
            state    <= DONE;
            PrDone_O <= 1'b1;
            PrErr_O  <= 1'b1;
          end
        end
        // an ack arriving on the expiry cycle takes priority over the timeout
        ACCESS: if (ack || cnt == CW'(TIMEOUT - 1)) begin
          state     <= DONE;
          DEV_Req_O <= '0;
          PrDone_O  <= 1'b1;
          PrErr_O   <= !ack;
          PrRD_O    <= ack ? (DEV_WE_O ? PrRD_O : rd_mux) : 32'hDEADBEEF;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: begin
          state    <= IDLE;
          PrDone_O <= 1'b0;
          PrErr_O  <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) {HWInt_O, int_meta} <= '0;
    else {HWInt_O, int_meta} <= {int_meta, DEV_Int_I};
  end
endmodule

// File: tb/tb_sys_bridge_mc.sv
// tb_sys_bridge_mc: directed checks of decode, lane steering, handshake, timeout,
// reset abandonment and interrupt synchronisation.
module tb_sys_bridge_mc;
  logic         clk = 0, rst = 1;
  logic         pr_req = 0, pr_we = 0, req3 = 0;
  logic [31:2]  pr_addr = '0;
  logic [31:0]  pr_wd = '0;
  logic [3:0]   be = '0;
  logic [127:0] dev_rd = {32'h33333333, 32'h22222222, 32'h12345678, 32'h11111111};
  logic [3:0]   dev_ack = '0, dev_int = '0;
  logic [31:0]  rd, dev_wd, rd3, dev_wd3;
  logic         busy, done, err, dev_we, busy3, done3, err3, dev_we3;
  logic [3:0]   dev_req, dev_be, hw_int, dev_be3;
  logic [1:0]   dev_addr, dev_addr3;
  logic [2:0]   dev_req3, hw_int3;
  int           n_checks = 0, n_fail = 0, n;
  logic         seen;

  always #5 clk = ~clk;

  sys_bridge_mc u_dut (
    .CLK_I(clk), .RST_I(rst), .PrReq_I(pr_req), .PrWE_I(pr_we), .PrAddr_I(pr_addr),
    .PrWD_I(pr_wd), .BE_I(be), .PrRD_O(rd), .PrBusy_O(busy), .PrDone_O(done),
    .PrErr_O(err), .DEV_Req_O(dev_req), .DEV_WE_O(dev_we), .DEV_BE_O(dev_be),
    .DEV_Addr_O(dev_addr), .DEV_WD_O(dev_wd), .DEV_RD_I(dev_rd), .DEV_Ack_I(dev_ack),
    .DEV_Int_I(dev_int), .HWInt_O(hw_int)
  );

  sys_bridge_mc #(.N_DEV(3)) u_dut3 (
    .CLK_I(clk), .RST_I(rst), .PrReq_I(req3), .PrWE_I(pr_we), .PrAddr_I(pr_addr),
    .PrWD_I(pr_wd), .BE_I(be), .PrRD_O(rd3), .PrBusy_O(busy3), .PrDone_O(done3),
    .PrErr_O(err3), .DEV_Req_O(dev_req3), .DEV_WE_O(dev_we3), .DEV_BE_O(dev_be3),
    .DEV_Addr_O(dev_addr3), .DEV_WD_O(dev_wd3), .DEV_RD_I(96'h0), .DEV_Ack_I(3'b0),
    .DEV_Int_I(3'b0), .HWInt_O(hw_int3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic we, input logic [31:0] ba, input logic [31:0] wd,
                       input logic [3:0] b);
    pr_we = we; pr_addr = ba[31:2]; pr_wd = wd; be = b; pr_req = 1;
    tick();
  endtask

  task automatic release_req();
    pr_req = 0; dev_ack = '0;
    tick();
  endtask

  initial begin
    tick();
    check("rst_rd", rd, 0);
    check("rst_req", {28'b0, dev_req}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_wd", dev_wd, 0);
    check("rst_int", {28'b0, hw_int}, 0);
    rst = 0;
    tick();
    // load from device 1, acked in the first access cycle
    dev_ack = 4'b0010;
    pr_we = 0; pr_addr = 30'(32'h104 >> 2); be = 4'hF; pr_req = 1;
    #1 check("busy_comb", {31'b0, busy}, 1);
    tick();
    check("ld_req", {28'b0, dev_req}, 4'b0010);
    check("ld_addr", {30'b0, dev_addr}, 2'b01);
    check("ld_we", {31'b0, dev_we}, 0);
    check("ld_nodone", {31'b0, done}, 0);
    tick();
    check("ld_done", {31'b0, done}, 1);
    check("ld_err", {31'b0, err}, 0);
    check("ld_rd", rd, 32'h12345678);
    check("ld_req_off", {28'b0, dev_req}, 0);
    release_req();
    check("ld_idle_done", {31'b0, done}, 0);
    check("ld_idle_busy", {31'b0, busy}, 0);
    // byte store to device 0 lane 2
    start(1, 32'h0, 32'hAABBCCDD, 4'b0100);
    check("sb_wd", dev_wd, 32'h00DD0000);
    check("sb_we", {31'b0, dev_we}, 1);
    check("sb_be", {28'b0, dev_be}, 4'b0100);
    check("sb_req", {28'b0, dev_req}, 4'b0001);
    dev_ack = 4'b0001;
    tick();
    check("sb_done", {31'b0, done}, 1);
    check("sb_rd_kept", rd, 32'h12345678);
    release_req();
    // half store to device 3 upper half
    start(1, 32'h300, 32'hAABBCCDD, 4'b1100);
    check("sh_wd", dev_wd, 32'hCCDD0000);
    check("sh_req", {28'b0, dev_req}, 4'b1000);
    dev_ack = 4'b1000;
    tick();
    check("sh_done", {31'b0, done}, 1);
    release_req();
    // byte store to lane 3 of device 1, word 3
    start(1, 32'h10C, 32'hAABBCCDD, 4'b1000);
    check("sb3_wd", dev_wd, 32'hDD000000);
    check("sb3_addr", {30'b0, dev_addr}, 2'b11);
    dev_ack = 4'b0010;
    tick();
    release_req();
    // lower-half store
    start(1, 32'h0, 32'hAABBCCDD, 4'b0011);
    check("sl_wd", dev_wd, 32'h0000CCDD);
    dev_ack = 4'b0001;
    tick();
    release_req();
    // device 2 never acks; other devices' acks must be ignored
    dev_ack = 4'b1011;
    start(0, 32'h200, 32'h0, 4'hF);
    n = 0;
    while (dev_req == 4'b0100 && n < 40) begin
      n++;
      tick();
    end
    check("to_len", n, 16);
    check("to_done", {31'b0, done}, 1);
    check("to_err", {31'b0, err}, 1);
    check("to_rd", rd, 32'hDEADBEEF);
    release_req();
    // ack on the final timeout cycle wins
    start(0, 32'h200, 32'h0, 4'hF);
    repeat (15) tick();
    check("late_req", {28'b0, dev_req}, 4'b0100);
    dev_ack = 4'b0100;
    tick();
    check("late_done", {31'b0, done}, 1);
    check("late_err", {31'b0, err}, 0);
    check("late_rd", rd, 32'h22222222);
    release_req();
    // illegal byte enable
    start(1, 32'h0, 32'h0, 4'b0110);
    check("be_done", {31'b0, done}, 1);
    check("be_err", {31'b0, err}, 1);
    check("be_req", {28'b0, dev_req}, 0);
    release_req();
    check("be_idle", {31'b0, done}, 0);
    // select 3 on a three-device bridge
    pr_we = 0; pr_addr = 30'(32'h300 >> 2); be = 4'hF; req3 = 1;
    tick();
    check("sel_done", {31'b0, done3}, 1);
    check("sel_err", {31'b0, err3}, 1);
    check("sel_req", {29'b0, dev_req3}, 0);
    req3 = 0;
    tick();
    check("sel_idle", {31'b0, done3}, 0);
    // reset in the second access cycle
    start(0, 32'h104, 32'h0, 4'hF);
    tick();
    check("ra_req_pre", {28'b0, dev_req}, 4'b0010);
    pr_req = 0; rst = 1;
    #1;
    check("ra_req", {28'b0, dev_req}, 0);
    check("ra_busy", {31'b0, busy}, 0);
    check("ra_rd", rd, 0);
    tick();
    rst = 0;
    seen = 0;
    repeat (3) begin
      tick();
      seen |= done;
    end
    check("ra_nodone", {31'b0, seen}, 0);
    dev_ack = 4'b0010;
    start(0, 32'h104, 32'h0, 4'hF);
    tick();
    check("ra_next_done", {31'b0, done}, 1);
    check("ra_next_rd", rd, 32'h12345678);
    release_req();
    // interrupts during an access
    dev_int = 4'b0101;
    start(0, 32'h0, 32'h0, 4'hF);
    check("int_1edge", {28'b0, hw_int}, 0);
    dev_ack = 4'b0001;
    tick();
    check("int_2edge", {28'b0, hw_int}, 4'b0101);
    check("int_acc_done", {31'b0, done}, 1);
    check("int_acc_rd", rd, 32'h11111111);
    release_req();
    dev_int = 4'b0000;
    tick();
    check("int_hold", {28'b0, hw_int}, 4'b0101);
    tick();
    check("int_clear", {28'b0, hw_int}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
